// File: rtl/uart_bus_master_pkg.sv
// Shared definitions for uart_bus_master: command opcodes, default response
// bytes, the controller state encoding and small state-decode helpers.
package uart_bus_master_pkg;

    // Command byte layout: opcode in [7:4], register address in [3:0].
    localparam logic [3:0] OP_WRITE = 4'h1;
    localparam logic [3:0] OP_READ  = 4'h2;

    localparam logic [7:0] ACK_BYTE_DEF = 8'hA5;
    localparam logic [7:0] NAK_BYTE_DEF = 8'h5A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_HI,
        ST_GET_LO,
        ST_BUS_WR,
        ST_BUS_RD,
        ST_RSP_ACK,
        ST_RSP_HI,
        ST_RSP_LO
    } state_e;

    // States in which the controller consumes bytes from the receiver.
    function automatic logic accepts_rx(input state_e s);
        return (s == ST_IDLE) || (s == ST_GET_HI) || (s == ST_GET_LO);
    endfunction

    // States in which a response byte is offered to the transmitter.
    function automatic logic drives_tx(input state_e s);
        return (s == ST_RSP_ACK) || (s == ST_RSP_HI) || (s == ST_RSP_LO);
    endfunction

endpackage

// File: rtl/uart_bus_master.sv
// uart_bus_master
//   Bus initiator between uart_rx/uart_tx and the 16-bit peripheral bus.
//   Decodes command bytes (WRITE: cmd, data MSB, data LSB; READ: cmd),
//   runs one write or read cycle on the bus and answers with ACK, NAK or
//   the two read-data bytes (MSB first).
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   rx_data/valid/ready byte stream from uart_rx (ready is a state decode)
//   tx_data/valid/ready response stream to uart_tx (valid held until ready)
//   cs/addr/rd/wr       peripheral select, register address and strobes
//   bus_dout/bus_din    write data to / read data from the peripheral
module uart_bus_master
    import uart_bus_master_pkg::*;
#(
    parameter int         DATA_W   = 16,
    parameter int         ADDR_W   = 4,
    parameter int         RD_WAIT  = 1,
    parameter int         TIMEOUT  = 50000,
    parameter logic [7:0] ACK_BYTE = ACK_BYTE_DEF,
    parameter logic [7:0] NAK_BYTE = NAK_BYTE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              cs,
    output logic [ADDR_W-1:0] addr,
    output logic              rd,
    output logic              wr,
    output logic [DATA_W-1:0] bus_dout,
    input  logic [DATA_W-1:0] bus_din
);

    localparam int                 TMR_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0]   TMR_LAST  = TMR_W'(TIMEOUT - 1);
    localparam logic [3:0]         WAIT_LAST = 4'(RD_WAIT);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   bus_dout_q, bus_dout_d;
    logic                cs_q, cs_d;
    logic                rd_q, rd_d;
    logic                wr_q, wr_d;
    logic                tx_valid_q, tx_valid_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic [7:0]          rd_lo_q, rd_lo_d;     // read-data LSB parked for RSP_LO
    logic [TMR_W-1:0]    timer_q, timer_d;     // inter-byte idle counter
    logic [3:0]          wait_q, wait_d;       // clocks spent in BUS_RD

    logic                rx_fire;
    logic                timer_expired;
    logic [3:0]          cmd_op;
    logic [ADDR_W-1:0]   cmd_addr;

    assign rx_ready      = accepts_rx(state_q);
    assign rx_fire       = rx_valid & rx_ready;
    assign timer_expired = (timer_q == TMR_LAST);
    assign cmd_op        = rx_data[7:4];
    assign cmd_addr      = rx_data[ADDR_W-1:0];

    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        bus_dout_d = bus_dout_q;
        tx_data_d  = tx_data_q;
        rd_lo_d    = rd_lo_q;
        timer_d    = timer_q;
        wait_d     = wait_q;

        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (rx_fire) begin
                    case (cmd_op)
                        OP_WRITE: begin
                            addr_d  = cmd_addr;
                            state_d = ST_GET_HI;
                        end
                        OP_READ: begin
                            addr_d  = cmd_addr;
                            wait_d  = '0;
                            state_d = ST_BUS_RD;
                        end
                        default: begin
                            tx_data_d = NAK_BYTE;
                            state_d   = ST_RSP_ACK;
                        end
                    endcase
                end
            end

            // A byte arriving on the expiry clock still wins: the sender
            // was not idle for the full window.
            ST_GET_HI: begin
                if (rx_fire) begin
                    bus_dout_d[15:8] = rx_data;
                    timer_d          = '0;
                    state_d          = ST_GET_LO;
                end else if (timer_expired) begin
                    timer_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            ST_GET_LO: begin
                if (rx_fire) begin
                    bus_dout_d[7:0] = rx_data;
                    timer_d         = '0;
                    state_d         = ST_BUS_WR;
                end else if (timer_expired) begin
                    timer_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            ST_BUS_WR: begin
                tx_data_d = ACK_BYTE;
                state_d   = ST_RSP_ACK;
            end

            // Data is sampled on the edge that ends the last strobe clock,
            // while cs/rd are still asserted.
            ST_BUS_RD: begin
                if (wait_q == WAIT_LAST) begin
                    tx_data_d = bus_din[15:8];
                    rd_lo_d   = bus_din[7:0];
                    state_d   = ST_RSP_HI;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            ST_RSP_ACK: begin
                if (tx_ready) state_d = ST_IDLE;
            end

            ST_RSP_HI: begin
                if (tx_ready) begin
                    tx_data_d = rd_lo_q;
                    state_d   = ST_RSP_LO;
                end
            end

            ST_RSP_LO: begin
                if (tx_ready) state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from the next state so the strobes and
        // tx_valid line up exactly with the state they belong to.
        cs_d       = (state_d == ST_BUS_WR) || (state_d == ST_BUS_RD);
        wr_d       = (state_d == ST_BUS_WR);
        rd_d       = (state_d == ST_BUS_RD);
        tx_valid_d = drives_tx(state_d);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    // NOTE: the asynchronous reset clears the strobes immediately, so an
    // aborted bus cycle never leaves cs/rd/wr asserted until the next edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            bus_dout_q <= '0;
            cs_q       <= 1'b0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            rd_lo_q    <= '0;
            timer_q    <= '0;
            wait_q     <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            bus_dout_q <= bus_dout_d;
            cs_q       <= cs_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            rd_lo_q    <= rd_lo_d;
            timer_q    <= timer_d;
            wait_q     <= wait_d;
        end
    end

    assign cs       = cs_q;
    assign rd       = rd_q;
    assign wr       = wr_q;
    assign addr     = addr_q;
    assign bus_dout = bus_dout_q;
    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_bus_master.sv
// Self-checking bench for uart_bus_master: directed scenarios followed by
// randomized commands checked against a register-file reference model.
module tb_uart_bus_master;

    localparam int         RD_WAIT = 1;
    localparam int         TIMEOUT = 16;
    localparam logic [7:0] ACK     = 8'hA5;
    localparam logic [7:0] NAK     = 8'h5A;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        cs;
    logic [3:0]  addr;
    logic        rd;
    logic        wr;
    logic [15:0] bus_dout;
    logic [15:0] bus_din;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: expected register contents, seeded identically to
    // the peripheral model and updated only by completed write commands.
    logic [15:0] seed_mem   [16];
    logic [15:0] ref_mem    [16];
    logic [15:0] periph_mem [16];

    int wr_pulses  = 0;
    int rd_cycles  = 0;
    int bad_strobe = 0;

    uart_bus_master #(
        .RD_WAIT (RD_WAIT),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .cs       (cs),
        .addr     (addr),
        .rd       (rd),
        .wr       (wr),
        .bus_dout (bus_dout),
        .bus_din  (bus_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Peripheral model and bus monitor.
    assign bus_din = (cs && rd) ? periph_mem[addr] : 16'h0000;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) periph_mem[i] <= seed_mem[i];
        end else begin
            if (cs && wr) periph_mem[addr] <= bus_dout;
            if (cs && wr) wr_pulses++;
            if (cs && rd) rd_cycles++;
            if ((wr || rd) && !cs) bad_strobe++;
            if (wr && rd) bad_strobe++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a byte and hold it until the DUT accepts it (bounded wait).
    task automatic send_byte(input logic [7:0] b);
        bit done;
        done     = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int k = 0; k < 200 && !done; k++) begin
            if (rx_ready) done = 1'b1;
            tick();
        end
        rx_valid = 1'b0;
        check("rx_accept", 32'(done), 32'd1);
    endtask

    // Collect one response byte after 'stall' clocks of back-pressure. While
    // stalled, a pending rx byte is offered and must not be taken.
    task automatic recv_byte(input string tag, input logic [7:0] exp, input int stall);
        rx_data  = 8'h3C;
        rx_valid = (stall > 0);
        for (int i = 0; i < stall; i++) begin
            check({tag, "_stall_valid"}, 32'(tx_valid), 32'd1);
            check({tag, "_stall_data"},  32'(tx_data),  32'(exp));
            check({tag, "_stall_rx_rdy"}, 32'(rx_ready), 32'd0);
            tick();
        end
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        check({tag, "_valid"}, 32'(tx_valid), 32'd1);
        check({tag, "_data"},  32'(tx_data),  32'(exp));
        tick();
        tx_ready = 1'b0;
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            check("gap_no_strobe", 32'({cs, wr, rd}), 32'd0);
            tick();
        end
    endtask

    // Issue one command and check bus cycle, latency and response against
    // the reference model.
    task automatic run_cmd(input logic [7:0] cmd, input logic [15:0] wdata,
                           input int stall, input int gap);
        logic [3:0]  op;
        logic [3:0]  a;
        logic [15:0] exp;
        int          wr0;
        int          rd0;
        op  = cmd[7:4];
        a   = cmd[3:0];
        wr0 = wr_pulses;
        rd0 = rd_cycles;
        if (op == 4'h1) begin
            send_byte(cmd);
            idle_gap(gap);
            send_byte(wdata[15:8]);
            idle_gap(gap);
            send_byte(wdata[7:0]);
            check("wr_strobe", 32'({cs, wr, rd}), 32'b110);
            check("wr_addr",   32'(addr),     32'(a));
            check("wr_data",   32'(bus_dout), 32'(wdata));
            check("wr_no_tx",  32'(tx_valid), 32'd0);
            tick();
            check("wr_end",    32'({cs, wr, rd}), 32'd0);
            recv_byte("ack", ACK, stall);
            ref_mem[a] = wdata;
            check("wr_pulses", 32'(wr_pulses - wr0), 32'd1);
            check("wr_rd_cyc", 32'(rd_cycles - rd0), 32'd0);
        end else if (op == 4'h2) begin
            exp = ref_mem[a];
            send_byte(cmd);
            for (int i = 0; i <= RD_WAIT; i++) begin
                check("rd_strobe", 32'({cs, wr, rd}), 32'b101);
                check("rd_addr",   32'(addr),     32'(a));
                check("rd_no_tx",  32'(tx_valid), 32'd0);
                tick();
            end
            check("rd_end", 32'({cs, wr, rd}), 32'd0);
            recv_byte("rd_hi", exp[15:8], stall);
            recv_byte("rd_lo", exp[7:0], 0);
            check("rd_cycles", 32'(rd_cycles - rd0), 32'(RD_WAIT + 1));
            check("rd_wr_pls", 32'(wr_pulses - wr0), 32'd0);
        end else begin
            send_byte(cmd);
            check("nak_no_strobe", 32'({cs, wr, rd}), 32'd0);
            recv_byte("nak", NAK, stall);
            check("nak_wr_pls", 32'(wr_pulses - wr0), 32'd0);
            check("nak_rd_cyc", 32'(rd_cycles - rd0), 32'd0);
        end
        // Back in IDLE straight after the last response handshake.
        check("idle_after", 32'({rx_ready, tx_valid, cs}), 32'b100);
    endtask

    initial begin
        logic [3:0]  op;
        logic [15:0] v;
        int          wr0;

        rst      = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            v           = 16'($urandom);
            seed_mem[i] = v;
            ref_mem[i]  = v;
        end
        seed_mem[5] = 16'hBEEF;
        ref_mem[5]  = 16'hBEEF;

        // 1: reset values
        repeat (5) @(posedge clk);
        #1;
        check("rst_strobes",  32'({cs, rd, wr}), 32'd0);
        check("rst_addr",     32'(addr),     32'd0);
        check("rst_bus_dout", 32'(bus_dout), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data",  32'(tx_data),  32'd0);
        check("rst_rx_ready", 32'(rx_ready), 32'd1);
        rst = 1'b1;
        tick();

        // 2: write 0x0023 to register 3
        run_cmd(8'h13, 16'h0023, 0, 0);
        // 3: read register 5 (BEEF)
        run_cmd(8'h25, 16'h0000, 0, 0);
        // 4: unknown opcode
        run_cmd(8'h70, 16'h0000, 0, 0);

        // 5: abandoned write times out; the next byte is a fresh command
        wr0 = wr_pulses;
        send_byte(8'h11);
        send_byte(8'h12);
        for (int i = 0; i < TIMEOUT; i++) begin
            check("to_no_tx", 32'({tx_valid, cs}), 32'd0);
            tick();
        end
        run_cmd(8'h21, 16'h0000, 0, 0);
        check("to_no_write", 32'(wr_pulses - wr0), 32'd0);
        // Gaps just inside the window must not abort the command.
        run_cmd(8'h14, 16'hC0DE, 0, TIMEOUT - 2);
        run_cmd(8'h24, 16'h0000, 0, 0);

        // 6: long back-pressure on the read-data MSB
        run_cmd(8'h25, 16'h0000, 30, 0);

        // Reset in the middle of a read cycle
        send_byte(8'h2A);
        check("pre_rst_strobe", 32'({cs, rd}), 32'b11);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_strobe", 32'({cs, rd, wr}), 32'd0);
        check("async_rst_tx",     32'(tx_valid),     32'd0);
        check("async_rst_rx_rdy", 32'(rx_ready),     32'd1);
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 16; i++) ref_mem[i] = seed_mem[i];
        tick();
        run_cmd(8'h2A, 16'h0000, 0, 0);

        // Randomized commands
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: op = 4'h1;
                4, 5, 6, 7: op = 4'h2;
                default: begin
                    op = 4'($urandom_range(0, 13));
                    if (op != 4'h0) op = op + 4'h2;
                end
            endcase
            run_cmd({op, 4'($urandom_range(0, 15))}, 16'($urandom),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        // Read back every register to confirm the accumulated state.
        for (int i = 0; i < 16; i++) run_cmd({4'h2, 4'(i)}, 16'h0000, 0, 0);

        check("strobe_hygiene", 32'(bad_strobe), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
